// File: rtl/key_lut_pipe.sv
// Programmable key->data lookup table with a single registered, ready/valid lookup stage.
// Multiple hits resolve to the lowest matching index; misses return default_out or zero.
module key_lut_pipe #(
  parameter int unsigned NR_KEY      = 4,
  parameter int unsigned KEY_LEN     = 7,
  parameter int unsigned DATA_LEN    = 32,
  parameter bit          HAS_DEFAULT = 1'b1,
  parameter int unsigned IDX_LEN     = $clog2(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                wr_en,
  input  logic [IDX_LEN-1:0]  wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                wr_vld,
  input  logic [DATA_LEN-1:0] default_out,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KEY_LEN-1:0]  req_key,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_LEN-1:0] resp_data,
  output logic                resp_hit,
  output logic [IDX_LEN-1:0]  resp_idx
);

  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];
  logic [NR_KEY-1:0]   vld_q;

  logic                resp_valid_q, resp_valid_d;
  logic [DATA_LEN-1:0] resp_data_q, resp_data_d;
  logic                resp_hit_q, resp_hit_d;
  logic [IDX_LEN-1:0]  resp_idx_q, resp_idx_d;

  logic                lk_hit;
  logic [IDX_LEN-1:0]  lk_idx;
  logic [DATA_LEN-1:0] lk_data;
  logic                accept;

  // Table storage. Indices >= NR_KEY never compare equal, so such writes drop out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < int'(NR_KEY); i++) begin
        key_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (clear) begin
      vld_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < int'(NR_KEY); i++) begin
        if (wr_idx == IDX_LEN'(i)) begin
          key_q[i]  <= wr_key;
          data_q[i] <= wr_data;
          vld_q[i]  <= wr_vld;
        end
      end
    end
  end

  // Scan from the top down so the lowest matching index is the last to assign.
  always_comb begin
    lk_hit  = 1'b0;
    lk_idx  = '0;
    lk_data = HAS_DEFAULT ? default_out : '0;
    for (int i = int'(NR_KEY) - 1; i >= 0; i--) begin
      if (vld_q[i] && (key_q[i] == req_key)) begin
        lk_hit  = 1'b1;
        lk_idx  = IDX_LEN'(i);
        lk_data = data_q[i];
      end
    end
  end

  assign req_ready = !resp_valid_q || resp_ready;
  assign accept    = req_valid && req_ready;

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_hit_d   = resp_hit_q;
    resp_idx_d   = resp_idx_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_data_d  = lk_data;
      resp_hit_d   = lk_hit;
      resp_idx_d   = lk_idx;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_hit_q   <= 1'b0;
      resp_idx_q   <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_hit_q   <= resp_hit_d;
      resp_idx_q   <= resp_idx_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_hit   = resp_hit_q;
  assign resp_idx   = resp_idx_q;

endmodule

// File: tb/tb_key_lut_pipe.sv
// Bench for key_lut_pipe: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a table/response model of the lookup.
module tb_key_lut_pipe;
  localparam int NR = 4;
  localparam int KL = 7;
  localparam int DL = 32;
  localparam int IL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          wr_en = 1'b0;
  logic [IL-1:0] wr_idx = '0;
  logic [KL-1:0] wr_key = '0;
  logic [DL-1:0] wr_data = '0;
  logic          wr_vld = 1'b0;
  logic [DL-1:0] default_out = 32'hDEAD_BEEF;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [KL-1:0] req_key = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DL-1:0] resp_data;
  logic          resp_hit;
  logic [IL-1:0] resp_idx;

  always #5 clk = ~clk;

  key_lut_pipe #(
    .NR_KEY     (NR),
    .KEY_LEN    (KL),
    .DATA_LEN   (DL),
    .HAS_DEFAULT(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_key     (wr_key),
    .wr_data    (wr_data),
    .wr_vld     (wr_vld),
    .default_out(default_out),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_key    (req_key),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_hit   (resp_hit),
    .resp_idx   (resp_idx)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the table as plain arrays and the single outstanding response.
  logic [KL-1:0] m_key  [NR];
  logic [DL-1:0] m_data [NR];
  bit            m_vld  [NR];
  bit            e_valid;
  logic [DL-1:0] e_data;
  bit            e_hit;
  int            e_idx;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_key[i] = '0; m_data[i] = '0; m_vld[i] = 0;
    end
    e_valid = 0; e_data = '0; e_hit = 0; e_idx = 0;
  endtask

  task automatic model_edge();
    bit ready;
    bit found;
    if (rst) return;
    ready = !e_valid || resp_ready;
    if (req_valid && ready) begin
      found = 0;
      e_valid = 1; e_hit = 0; e_idx = 0; e_data = default_out;
      for (int i = 0; i < NR; i++) begin
        if (!found && m_vld[i] && m_key[i] == req_key) begin
          found = 1; e_hit = 1; e_idx = i; e_data = m_data[i];
        end
      end
    end else if (resp_ready) begin
      e_valid = 0;
    end
    if (clear) begin
      for (int i = 0; i < NR; i++) m_vld[i] = 0;
    end else if (wr_en && int'(wr_idx) < NR) begin
      m_key[wr_idx] = wr_key; m_data[wr_idx] = wr_data; m_vld[wr_idx] = wr_vld;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("req_ready", 32'(req_ready), 32'(!e_valid || resp_ready));
      check("resp_valid", 32'(resp_valid), 32'(e_valid));
      if (e_valid) begin
        check("resp_data", resp_data, e_data);
        check("resp_hit", 32'(resp_hit), 32'(e_hit));
        check("resp_idx", 32'(resp_idx), e_idx);
      end
    end
  end

  task automatic write(input int idx, input logic [KL-1:0] k, input logic [DL-1:0] d,
                       input bit v);
    wr_en = 1; wr_idx = IL'(idx); wr_key = k; wr_data = d; wr_vld = v;
    tick();
    wr_en = 0;
  endtask

  task automatic lookup(input logic [KL-1:0] k);
    req_valid = 1; req_key = k;
    tick();
    req_valid = 0;
  endtask

  task automatic expect_resp(input string name, input bit hit, input int idx,
                             input logic [DL-1:0] d);
    check({name, ".valid"}, 32'(resp_valid), 32'd1);
    check({name, ".hit"}, 32'(resp_hit), 32'(hit));
    check({name, ".idx"}, 32'(resp_idx), idx);
    check({name, ".data"}, resp_data, d);
  endtask

  initial begin
    model_reset();
    #12;
    check("rst.valid", 32'(resp_valid), 32'd0);
    check("rst.data", resp_data, 32'd0);
    check("rst.hit", 32'(resp_hit), 32'd0);
    check("rst.idx", 32'(resp_idx), 32'd0);
    check("rst.req_ready", 32'(req_ready), 32'd1);
    rst = 0;
    tick();

    lookup(7'h13);
    expect_resp("miss_default", 0, 0, 32'hDEAD_BEEF);
    tick();

    write(1, 7'h13, 32'h1111_0000, 1);
    lookup(7'h13);
    expect_resp("hit_idx1", 1, 1, 32'h1111_0000);

    write(2, 7'h05, 32'hA, 1);
    write(3, 7'h05, 32'hB, 1);
    lookup(7'h05);
    expect_resp("dup_low", 1, 2, 32'hA);
    write(2, 7'h05, 32'h0, 0);
    lookup(7'h05);
    expect_resp("dup_after_inval", 1, 3, 32'hB);
    tick();

    // Backpressure: first response held, second request waits.
    req_valid = 1; req_key = 7'h05; resp_ready = 1;
    tick();
    req_key = 7'h13; resp_ready = 0;
    #1;
    check("bp.req_ready", 32'(req_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      expect_resp("bp.hold", 1, 3, 32'hB);
    end
    resp_ready = 1;
    tick();
    expect_resp("bp.second", 1, 1, 32'h1111_0000);
    req_key = 7'h7F;
    tick();
    expect_resp("bp.third", 0, 0, 32'hDEAD_BEEF);
    req_valid = 0;
    tick();

    // Write and lookup of the same key in one cycle.
    wr_en = 1; wr_idx = 0; wr_key = 7'h20; wr_data = 32'h55; wr_vld = 1;
    req_valid = 1; req_key = 7'h20;
    tick();
    wr_en = 0;
    expect_resp("samecyc.miss", 0, 0, 32'hDEAD_BEEF);
    tick();
    req_valid = 0;
    expect_resp("samecyc.hit", 1, 0, 32'h55);

    // Clear beats a simultaneous write.
    clear = 1; wr_en = 1; wr_idx = 0; wr_key = 7'h20; wr_data = 32'h99; wr_vld = 1;
    tick();
    clear = 0; wr_en = 0;
    lookup(7'h20);
    expect_resp("clr.k20", 0, 0, 32'hDEAD_BEEF);
    lookup(7'h13);
    expect_resp("clr.k13", 0, 0, 32'hDEAD_BEEF);
    lookup(7'h05);
    expect_resp("clr.k05", 0, 0, 32'hDEAD_BEEF);
    tick();

    // Randomized traffic; small key pool so hits and duplicates are common.
    for (int c = 0; c < 3000; c++) begin
      clear       = ($urandom_range(0, 31) == 0);
      wr_en       = ($urandom_range(0, 3) == 0);
      wr_idx      = IL'($urandom_range(0, NR - 1));
      wr_key      = KL'($urandom_range(0, 7));
      wr_data     = $urandom;
      wr_vld      = ($urandom_range(0, 4) != 0);
      default_out = $urandom;
      req_valid   = $urandom_range(0, 1) == 1;
      req_key     = KL'($urandom_range(0, 7));
      resp_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    clear = 0; wr_en = 0; req_valid = 0; resp_ready = 1; default_out = 32'hDEAD_BEEF;
    tick();

    // Asynchronous reset while a response is pending.
    write(0, 7'h05, 32'h77, 1);
    req_valid = 1; req_key = 7'h05; resp_ready = 0;
    tick();
    req_valid = 0;
    expect_resp("pre_rst", 1, 0, 32'h77);
    #2;
    rst = 1;
    model_reset();
    #1;
    check("midrst.valid", 32'(resp_valid), 32'd0);
    check("midrst.req_ready", 32'(req_ready), 32'd1);
    #3;
    rst = 0; resp_ready = 1;
    tick();
    lookup(7'h05);
    expect_resp("post_rst", 0, 0, 32'hDEAD_BEEF);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/key_lut_pipe.md
Name: key_lut_pipe

Overview:
- Programmable key→data lookup table with a registered, handshaked lookup port.
- Generalised successor of the combinational key-select mux. Table entries are held in registers and rewritable at run time. Multiple hits resolve by priority (lowest index wins) instead of being OR-merged. The result carries hit and index flags.
- Used in the NPC for decode/CSR-address style lookups where the table contents change and the result must be registered for timing.

Parameters:
- NR_KEY, 4, number of table entries (≥2)
- KEY_LEN, 7, key width in bits
- DATA_LEN, 32, data width in bits
- HAS_DEFAULT, 1, 1: a miss returns default_out; 0: a miss returns all-zero data
- IDX_LEN, $clog2(NR_KEY), width of entry index fields (derived; must not be overridden)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  invalidate all entries
- wr_en  in  1  write one table entry
- wr_idx  in  IDX_LEN  entry to write
- wr_key  in  KEY_LEN  key stored in the entry
- wr_data  in  DATA_LEN  data stored in the entry
- wr_vld  in  1  valid bit stored in the entry (0 = invalidate that entry)
- default_out  in  DATA_LEN  data returned on a miss when HAS_DEFAULT=1
- req_valid  in  1  lookup request valid
- req_ready  out  1  lookup request can be accepted
- req_key  in  KEY_LEN  key to look up
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts the response
- resp_data  out  DATA_LEN  looked-up data
- resp_hit  out  1  1 if exactly one or more valid entries matched
- resp_idx  out  IDX_LEN  index of the winning entry (0 on miss)

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high. Reset takes effect immediately and does not wait for a clock edge.
- Reset values:
  - All entry valid bits are 0. Entry keys and data are 0.
  - resp_valid=0, resp_data=0, resp_hit=0, resp_idx=0.
  - req_ready is therefore 1 out of reset.
- Table writes:
  - On a rising edge with wr_en=1 and wr_idx<NR_KEY, the entry's {key, data, valid} are loaded from {wr_key, wr_data, wr_vld}.
  - If wr_idx≥NR_KEY (non-power-of-two NR_KEY), the write is ignored.
- Clear:
  - On a rising edge with clear=1, every valid bit goes to 0. Keys and data are unchanged.
  - If clear and wr_en are both 1 in the same cycle, clear wins and the write is dropped.
- Match rule:
  - Entry i matches when its valid bit is 1 and its key == req_key.
  - Winner is the lowest matching index.
  - On a hit: data=entry data, hit=1, idx=winner.
  - On a miss: data=default_out if HAS_DEFAULT else 0, hit=0, idx=0.
  - default_out is sampled in the accept cycle.
- Handshake (single registered stage):
  - req_ready = !resp_valid || resp_ready. This is combinational and has no dependency on req_valid.
  - Accept occurs when req_valid && req_ready.
  - On accept, the lookup result is registered and resp_valid=1 on the next edge. Latency is one cycle, and back-to-back throughput is 1 per cycle when resp_ready=1.
  - If resp_valid=1 and resp_ready=0, the response is held stable: resp_data, resp_hit and resp_idx do not change, and no request is accepted.
  - If resp_ready=1 and there is no accept, resp_valid→0 on the next edge. Data registers may keep their old values.
- Simultaneous write/clear and lookup: the lookup uses the table contents before the edge. Writes and clears become visible to requests accepted from the following cycle onward.
- Held responses are unaffected by later table writes.
- Reset mid-operation: any pending response is discarded immediately and the table is emptied.
- No $display or other simulation-only side effects in the RTL.

Test Plan:
- Reset, then request key 7'h13 → one cycle later resp_valid=1, resp_hit=0, resp_idx=0, resp_data=default_out (e.g. 32'hDEAD_BEEF); with HAS_DEFAULT=0 → resp_data=0.
- Write idx1={7'h13, 32'h1111_0000, vld 1}, then request 7'h13 → resp_hit=1, resp_idx=1, resp_data=32'h1111_0000.
- Duplicate keys: write idx2 and idx3 both key 7'h05 with data 32'hA and 32'hB, then request 7'h05 → resp_idx=2, resp_data=32'hA. Invalidate idx2 (wr_vld=0), request again → resp_idx=3, resp_data=32'hB.
- Backpressure:
  - Stream of 3 requests with resp_ready low from cycle 2 → req_ready=0, the first response is held stable for the whole stall, and the second request is not lost.
  - Release resp_ready → responses arrive in order at 1 per cycle.
- Same-cycle write and request to the same key: request 7'h20 while writing idx0={7'h20, 32'h55} → miss response. The next request → hit with data 32'h55.
- Same-cycle clear and wr_en: clear and wr_en in the same cycle → all lookups miss afterwards.
- Reset mid-operation: assert rst asynchronously between clock edges while resp_valid=1 → resp_valid drops immediately and the table reads as empty afterwards.
